// File: rtl/net_tx_burst.sv
// net_tx_burst: multi-lane serial burst transmitter with preamble, sync, framed words, per-lane CRC trailer, hold and gap
module net_tx_burst #(
  parameter int          BITS            = 64,
  parameter int          LANES           = 1,
  parameter logic [63:0] SYNC            = 64'h307A1AFD8FE3A9DA,
  parameter int          PREAMBLE_CYCLES = BITS/LANES,
  parameter int          RESYNC_WORDS    = 15,
  parameter int          HOLD_CYCLES     = 9,
  parameter int          GAP_CYCLES      = BITS/LANES,
  parameter bit          CRC_EN          = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [BITS-1:0]  in_data,
  input  logic             in_end,
  output logic             in_pull,
  output logic [LANES-1:0] out_data,
  output logic             out_txen
);
  localparam int W  = BITS/LANES;
  localparam int M1 = (W+2 > 18) ? W+2 : 18;
  localparam int M2 = (M1 > PREAMBLE_CYCLES) ? M1 : PREAMBLE_CYCLES;
  localparam int M3 = (M2 > HOLD_CYCLES) ? M2 : HOLD_CYCLES;
  localparam int M4 = (M3 > GAP_CYCLES) ? M3 : GAP_CYCLES;
  localparam int CW = $clog2(M4+1);
  localparam logic [CW-1:0] C_PL = CW'(PREAMBLE_CYCLES-1);
  localparam logic [CW-1:0] C_SL = CW'(W-1);
  localparam logic [CW-1:0] C_DL = CW'(W+1);
  localparam logic [CW-1:0] C_CL = CW'(17);
  localparam logic [CW-1:0] C_HL = CW'(HOLD_CYCLES-1);
  localparam logic [CW-1:0] C_GL = CW'(GAP_CYCLES-1);
  localparam logic [CW-1:0] C_2  = CW'(2);
  localparam logic          P_ODD = 1'((PREAMBLE_CYCLES-1)%2);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEAD = 3'd1;
  localparam logic [2:0] S_PRE  = 3'd2;
  localparam logic [2:0] S_SYNC = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4;
  localparam logic [2:0] S_CRC  = 3'd5;
  localparam logic [2:0] S_HOLD = 3'd6;
  localparam logic [2:0] S_GAP  = 3'd7;

  logic [2:0]       r_st;
  logic [CW-1:0]    r_cnt;
  logic [7:0]       r_bud;
  logic [BITS-1:0]  r_sh;
  logic             r_end;
  logic [15:0]      r_crc [LANES];
  logic [LANES-1:0] r_l1;
  logic             r_t1;
  logic [BITS-1:0]  w_shr;
  logic [LANES-1:0] w_lsb;
  logic [LANES-1:0] w_msb;
  logic [LANES-1:0] w_line;
  logic             w_txen;
  logic             w_pre;
  logic             w_bnd;
  logic             w_take;

  // Line value for the current state, plus lane-wise shift and word-boundary decode
  always_comb begin
    w_shr = '0;
    w_lsb = '0;
    w_msb = '0;
    for (int i = 0; i < LANES; i++) begin
      w_shr[i*W +: W] = r_sh[i*W +: W] >> 1;
      w_lsb[i]        = r_sh[i*W];
      w_msb[i]        = r_crc[i][15];
    end
    w_pre  = r_cnt[0] ^ P_ODD;
    w_bnd  = (r_st == S_SYNC && r_cnt == C_SL) ||
             (r_st == S_DATA && r_cnt == C_DL && !(CRC_EN && r_end)) ||
             (r_st == S_CRC  && r_cnt == C_CL);
    w_take = in_valid && r_bud != 8'd0;
    w_line = r_st == S_PRE  ? {LANES{w_pre}} :
             r_st == S_SYNC ? w_lsb :
             r_st == S_DATA ? (r_cnt == '0 ? {LANES{r_end}} : r_cnt == CW'(1) ? {LANES{~r_end}} : w_lsb) :
             r_st == S_CRC  ? (r_cnt < C_2 ? {LANES{1'b1}} : w_msb) : '0;
    w_txen = r_st inside {S_LEAD, S_PRE, S_SYNC, S_DATA, S_CRC, S_HOLD};
  end

  // Burst sequencer: state, symbol counter, word budget, capture and pull strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st    <= S_IDLE;
      r_cnt   <= '0;
      r_bud   <= '0;
      r_sh    <= '0;
      r_end   <= 1'b0;
      in_pull <= 1'b0;
    end else begin
      in_pull <= 1'b0;
      r_cnt   <= r_cnt + CW'(1);
      if (r_st == S_SYNC || (r_st == S_DATA && r_cnt >= C_2)) r_sh <= w_shr;
      if (w_bnd) begin
        r_cnt <= '0;
        if (w_take) begin
          r_st    <= S_DATA;
          r_sh    <= in_data;
          r_end   <= in_end;
          in_pull <= 1'b1;
          r_bud   <= r_bud - 8'd1;
        end else r_st <= S_HOLD;
      end else if (r_st == S_IDLE) begin
        r_cnt <= '0;
        if (in_valid) r_st <= S_LEAD;
      end else if (r_st == S_LEAD) begin
        r_cnt <= '0;
        r_st  <= S_PRE;
      end else if (r_st == S_PRE && r_cnt == C_PL) begin
        r_cnt <= '0;
        r_st  <= S_SYNC;
        r_sh  <= SYNC[BITS-1:0];
        r_bud <= 8'(RESYNC_WORDS);
      end else if (r_st == S_DATA && r_cnt == C_DL) begin
        r_cnt <= '0;
        r_st  <= S_CRC;
      end else if (r_st == S_HOLD && r_cnt == C_HL) begin
        r_cnt <= '0;
        r_st  <= S_GAP;
      end else if (r_st == S_GAP && r_cnt == C_GL) begin
        r_cnt <= '0;
        r_st  <= S_IDLE;
      end
    end
  end

  // Per-lane CRC: accumulate payload bits, shift out as trailer, re-init once trailer is done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) r_crc[i] <= 16'hFFFF;
    end else begin
      for (int i = 0; i < LANES; i++)
        if (r_st == S_DATA && r_cnt >= C_2)
          r_crc[i] <= {r_crc[i][14:0], 1'b0} ^ ((r_crc[i][15] ^ w_lsb[i]) ? 16'h1021 : 16'h0000);
        else if (r_st == S_CRC && r_cnt == C_CL)
          r_crc[i] <= 16'hFFFF;
        else if (r_st == S_CRC && r_cnt >= C_2)
          r_crc[i] <= r_crc[i] << 1;
    end
  end

  // Two-stage output register so the pins lag the sequencer by two cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_l1     <= '0;
      r_t1     <= 1'b0;
      out_data <= '0;
      out_txen <= 1'b0;
    end else begin
      r_l1     <= w_line;
      r_t1     <= w_txen;
      out_data <= r_l1;
      out_txen <= r_t1;
    end
  end
endmodule

// File: tb/tb_net_tx_burst.sv
// tb_net_tx_burst: randomized bursts checked cycle-by-cycle against a frame-level reference model
module tb_net_tx_burst;
  localparam int BITS = 16, LANES = 2, W = 8, P = 4, R = 3, H = 3, G = 5;
  localparam logic [63:0] SY = 64'h307A1AFD8FE3A9DA;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [BITS-1:0]  in_data;
  logic             in_end;
  logic             in_pull;
  logic [LANES-1:0] out_data;
  logic             out_txen;

  int checks = 0;
  int errors = 0;
  logic [BITS-1:0] wd [16];
  logic            we [16];
  logic [15:0]     mcrc [LANES];
  logic [LANES:0]  eq [$];

  net_tx_burst #(
    .BITS(BITS), .LANES(LANES), .SYNC(SY), .PREAMBLE_CYCLES(P), .RESYNC_WORDS(R),
    .HOLD_CYCLES(H), .GAP_CYCLES(G), .CRC_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_end(in_end),
    .in_pull(in_pull), .out_data(out_data), .out_txen(out_txen)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LANES-1:0] rep(logic b);
    return {LANES{b}};
  endfunction

  function automatic logic [15:0] crc_step(logic [15:0] c, logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  task automatic build(int n);
    int k = 0;
    int rem = n;
    int m;
    logic [LANES-1:0] v;
    logic [63:0] sy = SY;
    logic [BITS-1:0] d;
    eq.delete();
    do begin
      if (k > 0) eq.push_back('0);
      eq.push_back({1'b1, rep(1'b0)});
      for (int j = 0; j < P; j++) eq.push_back({1'b1, rep(1'((P-1-j)%2))});
      for (int c = 0; c < W; c++) begin
        for (int i = 0; i < LANES; i++) v[i] = sy[i*W+c];
        eq.push_back({1'b1, v});
      end
      m = rem < R ? rem : R;
      for (int q = 0; q < m; q++) begin
        d = wd[k];
        eq.push_back({1'b1, rep(we[k])});
        eq.push_back({1'b1, rep(!we[k])});
        for (int c = 0; c < W; c++) begin
          for (int i = 0; i < LANES; i++) begin
            v[i] = d[i*W+c];
            mcrc[i] = crc_step(mcrc[i], v[i]);
          end
          eq.push_back({1'b1, v});
        end
        if (we[k]) begin
          eq.push_back({1'b1, rep(1'b1)});
          eq.push_back({1'b1, rep(1'b1)});
          for (int b = 15; b >= 0; b--) begin
            for (int i = 0; i < LANES; i++) v[i] = mcrc[i][b];
            eq.push_back({1'b1, v});
          end
          for (int i = 0; i < LANES; i++) mcrc[i] = 16'hFFFF;
        end
        k++;
        rem--;
      end
      repeat (H) eq.push_back({1'b1, rep(1'b0)});
      repeat (G) eq.push_back('0);
    end while (rem > 0);
    repeat (4) eq.push_back('0);
  endtask

  task automatic run(string tag, int n, int mode);
    int idx = 0;
    int pulls = 0;
    logic [LANES:0] x;
    build(n);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = wd[0];
    in_end   = we[0];
    for (int e = 0; e < eq.size() + 2; e++) begin
      @(posedge clk);
      #1;
      x = (e < 2) ? '0 : eq[e-2];
      chk(tag, {29'd0, out_txen, out_data}, {29'd0, x});
      if (in_pull) begin
        pulls++;
        idx++;
        if (idx < n) begin
          in_data = wd[idx];
          in_end  = we[idx];
        end else in_valid = 1'b0;
      end
      if (mode == 1 && e == 0) in_valid = 1'b0;
      if (mode == 1 && e == P + 3) in_valid = 1'b1;
    end
    chk({tag, "_pulls"}, pulls, n);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_end = 1'b0;
    for (int i = 0; i < LANES; i++) mcrc[i] = 16'hFFFF;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pins", {29'd0, in_pull, out_txen, out_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_pins", {29'd0, in_pull, out_txen, out_data}, 32'd0);

    for (int k = 0; k < 7; k++) begin
      wd[k] = BITS'($urandom);
      we[k] = 1'($urandom_range(0, 1));
    end
    run("budget", 7, 0);

    wd[0] = 16'h1234; we[0] = 1'b0;
    wd[1] = 16'h5678; we[1] = 1'b1;
    wd[2] = BITS'($urandom); we[2] = 1'b1;
    run("crc", 3, 0);

    for (int k = 0; k < 4; k++) begin
      wd[k] = BITS'($urandom);
      we[k] = 1'($urandom_range(0, 1));
    end
    run("handshake", 4, 1);

    repeat (6) begin
      n = $urandom_range(1, 10);
      for (int k = 0; k < n; k++) begin
        wd[k] = BITS'($urandom);
        we[k] = 1'($urandom_range(0, 1));
      end
      run("random", n, 0);
    end

    @(negedge clk);
    in_valid = 1'b1;
    in_data  = BITS'($urandom);
    in_end   = 1'b1;
    repeat (P + W + 5) @(posedge clk);
    #2;
    chk("pre_reset_txen", {31'd0, out_txen}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_reset", {29'd0, in_pull, out_txen, out_data}, 32'd0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < LANES; i++) mcrc[i] = 16'hFFFF;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      chk("post_reset_quiet", {29'd0, in_pull, out_txen, out_data}, 32'd0);
    end

    wd[0] = BITS'($urandom); we[0] = 1'b0;
    wd[1] = BITS'($urandom); we[1] = 1'b1;
    run("crc_after_reset", 2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
